// File: rtl/reset_pkg.sv
// Shared definitions for the reset sequencer.
// Contents: FSM state encoding, cause register bit positions and reset values,
// and a small max helper used to size counters.
package reset_pkg;

    typedef enum logic [1:0] {
        StPorHold,
        StHold,
        StStagger,
        StRun
    } rst_state_e;

    localparam int unsigned CauseBitPor  = 0;
    localparam int unsigned CauseBitWdt  = 1;
    localparam int unsigned CauseBitTrap = 2;
    localparam int unsigned CauseBitExt  = 3;
    localparam int unsigned CauseBitSw   = 4;

    localparam logic [7:0] CauseRstVal  = 8'h01;
    localparam logic [7:0] CauseValidMask = 8'h1F;
    localparam logic [7:0] HoldRstVal   = 8'd16;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Register/control bus of the reset sequencer.
// master: drives hold/cause writes and the software reset strobe, reads hold_out/cause_out.
// slave : the sequencer side.
interface reset_sequencer_if;

    logic [7:0] hold_in;
    logic       hold_write;
    logic [7:0] cause_in;
    logic       cause_write;
    logic       sw_reset;
    logic [7:0] hold_out;
    logic [7:0] cause_out;

    modport master (
        output hold_in, hold_write, cause_in, cause_write, sw_reset,
        input  hold_out, cause_out
    );

    modport slave (
        input  hold_in, hold_write, cause_in, cause_write, sw_reset,
        output hold_out, cause_out
    );

endinterface

// File: rtl/reset_debounce.sv
// Synchronizer and debouncer for the external reset button.
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   ext_reset_ni raw asynchronous button input, active-low
//   event_o      single-cycle pulse, once per qualified low period
module reset_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ext_reset_ni,
    output logic event_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            fired_q, fired_d;
    logic            event_q, event_d;

    always_comb begin
        cnt_d   = cnt_q;
        fired_d = fired_q;
        event_d = 1'b0;
        if (sync_q[1]) begin
            cnt_d   = '0;
            fired_d = 1'b0;
        end else if (!fired_q) begin
            // fired_q blocks further pulses until the button is released
            if (cnt_q == CntLast) begin
                event_d = 1'b1;
                fired_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            fired_q <= 1'b0;
            event_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], ext_reset_ni};
            cnt_q   <= cnt_d;
            fired_q <= fired_d;
            event_q <= event_d;
        end
    end

    assign event_o = event_q;

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds peripherals and CPU in reset after power-on and after
// any reset event, releasing peripherals first and the CPU STAGGER_CYCLES later.
// Ports:
//   clk              system clock
//   power_on_reset_n asynchronous active-low power-on reset
//   wdt_reset, trap  synchronous active-high reset requests
//   ext_reset_n      asynchronous active-low button
//   bus              hold/cause register access and software reset (slave)
//   periph_reset     active-high peripheral reset (registered)
//   cpu_reset        active-high CPU reset (registered)
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int unsigned POR_CYCLES      = 64,
    parameter int unsigned STAGGER_CYCLES  = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               power_on_reset_n,
    input  logic               wdt_reset,
    input  logic               trap,
    input  logic               ext_reset_n,
    reset_sequencer_if.slave   bus,
    output logic               periph_reset,
    output logic               cpu_reset
);

    // Wide enough for the POR/stagger counts and an 8-bit hold length.
    localparam int unsigned CntW =
        max_u(max_u($clog2(POR_CYCLES), $clog2(STAGGER_CYCLES)), 8);
    localparam logic [CntW-1:0] PorLast     = CntW'(POR_CYCLES - 1);
    localparam logic [CntW-1:0] StaggerLast = CntW'(STAGGER_CYCLES - 1);

    rst_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      hold_len_q, hold_len_d;
    logic            periph_q, periph_d;
    logic            cpu_q, cpu_d;
    logic [7:0]      hold_q, hold_d;
    logic [7:0]      cause_q, cause_d;

    logic            ext_event;
    logic            sw_ok;
    logic [7:0]      set_bits;
    logic [7:0]      clr_mask;
    logic            any_event;

    reset_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i        (clk),
        .rst_ni       (power_on_reset_n),
        .ext_reset_ni (ext_reset_n),
        .event_o      (ext_event)
    );

    // Software-side accesses are only honoured while the CPU is out of reset.
    assign sw_ok = bus.sw_reset & ~cpu_q;

    always_comb begin
        set_bits               = '0;
        set_bits[CauseBitWdt]  = wdt_reset;
        set_bits[CauseBitTrap] = trap;
        set_bits[CauseBitExt]  = ext_event;
        set_bits[CauseBitSw]   = sw_ok;
    end

    assign any_event = |set_bits;
    assign clr_mask  = (bus.cause_write && !cpu_q) ? bus.cause_in : 8'h00;
    // Set wins over clear.
    assign cause_d   = ((cause_q & ~clr_mask) | set_bits) & CauseValidMask;
    assign hold_d    = (bus.hold_write && !cpu_q) ? bus.hold_in : hold_q;

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_len_d = hold_len_q;
        if (state_q != StPorHold && any_event) begin
            // Every event (re)starts HOLD with the length latched at entry.
            state_d    = StHold;
            cnt_d      = '0;
            hold_len_d = (hold_q == 8'd0) ? 8'd1 : hold_q;
        end else begin
            unique case (state_q)
                StPorHold: begin
                    if (cnt_q == PorLast) begin
                        state_d = StStagger;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StHold: begin
                    if (cnt_q == CntW'(hold_len_q - 8'd1)) begin
                        state_d = StStagger;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StStagger: begin
                    if (cnt_q == StaggerLast) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StRun: begin
                end
            endcase
        end
    end

    // Outputs decoded from the next state so they can be registered.
    always_comb begin
        periph_d = (state_d == StPorHold) || (state_d == StHold);
        cpu_d    = (state_d != StRun);
    end

    always_ff @(posedge clk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            state_q    <= StPorHold;
            cnt_q      <= '0;
            hold_len_q <= HoldRstVal;
            periph_q   <= 1'b1;
            cpu_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_len_q <= hold_len_d;
            periph_q   <= periph_d;
            cpu_q      <= cpu_d;
        end
    end

    always_ff @(posedge clk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            hold_q  <= HoldRstVal;
            cause_q <= CauseRstVal;
        end else begin
            hold_q  <= hold_d;
            cause_q <= cause_d;
        end
    end

    assign periph_reset  = periph_q;
    assign cpu_reset     = cpu_q;
    assign bus.hold_out  = hold_q;
    assign bus.cause_out = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer (default parameters).
module tb_reset_sequencer;

    logic clk;
    logic por_n;
    logic wdt;
    logic trap;
    logic ext_n;
    logic periph;
    logic cpu;

    reset_sequencer_if bus ();

    reset_sequencer dut (
        .clk              (clk),
        .power_on_reset_n (por_n),
        .wdt_reset        (wdt),
        .trap             (trap),
        .ext_reset_n      (ext_n),
        .bus              (bus),
        .periph_reset     (periph),
        .cpu_reset        (cpu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    exp;
    } sb_t;

    sb_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    typedef struct {
        logic [7:0] hold;
        logic       wdt;
        logic       trap;
        logic       sw;
        logic       cwr;
        logic [7:0] cin;
        logic [7:0] exp_cause;
        logic       exp_first;
        int         exp_per;
        int         exp_cpu;
    } vec_t;

    vec_t vecs[8];

    task automatic sb_push(input string name, input int exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic sb_check(input int act);
        sb_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d, nothing expected", act);
        end else begin
            e = sb.pop_front();
            if (act != e.exp) begin
                n_fail++;
                $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
            end
        end
    endtask

    task automatic clear_drives();
        wdt             = 1'b0;
        trap            = 1'b0;
        bus.sw_reset    = 1'b0;
        bus.cause_write = 1'b0;
        bus.hold_write  = 1'b0;
    endtask

    // Sample index k = sample after the k-th posedge following the call.
    // Records the first k at which each reset reads 0; 0 means never (timeout).
    // inj = {sw, trap, wdt} driven for one cycle at sample inj_at.
    task automatic measure(input int inj_at, input logic [2:0] inj,
                           output int per_fall, output int cpu_fall, output int first_both);
        per_fall   = 0;
        cpu_fall   = 0;
        first_both = 0;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            clear_drives();
            if (k == inj_at) {bus.sw_reset, trap, wdt} = inj;
            if (k == 1) first_both = int'(periph & cpu);
            if (per_fall == 0 && !periph) per_fall = k;
            if (cpu_fall == 0 && !cpu) cpu_fall = k;
            if (per_fall != 0 && cpu_fall != 0) break;
        end
    endtask

    task automatic clear_cause();
        @(negedge clk);
        bus.cause_write = 1'b1;
        bus.cause_in    = 8'hFF;
        @(negedge clk);
        clear_drives();
    endtask

    int pf, cf, fb, rises;
    logic prev_cpu;

    initial begin
        vecs[0] = '{8'd16, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 17, 21};
        vecs[1] = '{8'd16, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h04, 1'b1, 17, 21};
        vecs[2] = '{8'd3,  1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h10, 1'b1, 4,  8};
        vecs[3] = '{8'd0,  1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 2,  6};
        vecs[4] = '{8'd5,  1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h16, 1'b1, 6,  10};
        vecs[5] = '{8'd16, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 8'h02, 1'b1, 17, 21};
        vecs[6] = '{8'd1,  1'b0, 1'b1, 1'b0, 1'b1, 8'h04, 8'h04, 1'b1, 2,  6};
        vecs[7] = '{8'd16, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1,  1};

        por_n        = 1'b0;
        ext_n        = 1'b1;
        bus.hold_in  = 8'h00;
        bus.cause_in = 8'h00;
        clear_drives();

        // Reset values while power-on reset is held
        repeat (3) @(negedge clk);
        sb_push("rst_periph", 1); sb_check(int'(periph));
        sb_push("rst_cpu", 1);    sb_check(int'(cpu));
        sb_push("rst_cause", 8'h01); sb_check(int'(bus.cause_out));
        sb_push("rst_hold", 16);  sb_check(int'(bus.hold_out));

        // Power-on sequence
        por_n = 1'b1;
        sb_push("por_first_both", 1);
        sb_push("por_periph_fall", 64);
        sb_push("por_cpu_fall", 68);
        measure(0, 3'b000, pf, cf, fb);
        sb_check(fb); sb_check(pf); sb_check(cf);
        sb_push("por_cause", 8'h01); sb_check(int'(bus.cause_out));

        // Table-driven events from RUN
        foreach (vecs[i]) begin
            @(negedge clk);
            bus.cause_write = 1'b1;
            bus.cause_in    = 8'hFF;
            bus.hold_write  = 1'b1;
            bus.hold_in     = vecs[i].hold;
            @(negedge clk);
            clear_drives();
            wdt             = vecs[i].wdt;
            trap            = vecs[i].trap;
            bus.sw_reset    = vecs[i].sw;
            bus.cause_write = vecs[i].cwr;
            bus.cause_in    = vecs[i].cin;
            sb_push($sformatf("vec%0d_first_both", i), int'(vecs[i].exp_first));
            sb_push($sformatf("vec%0d_periph_fall", i), vecs[i].exp_per);
            sb_push($sformatf("vec%0d_cpu_fall", i), vecs[i].exp_cpu);
            sb_push($sformatf("vec%0d_cause", i), int'(vecs[i].exp_cause));
            measure(0, 3'b000, pf, cf, fb);
            sb_check(fb); sb_check(pf); sb_check(cf);
            sb_check(int'(bus.cause_out));
        end

        // External button: 15 low cycles must not qualify
        clear_cause();
        @(negedge clk);
        ext_n = 1'b0;
        rises = 0;
        sb_push("ext_short_no_reset", 0);
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (k == 14) ext_n = 1'b1;
            if (cpu) rises++;
        end
        sb_check(rises);

        // 40 low cycles: exactly one HOLD
        ext_n = 1'b0;
        rises = 0;
        prev_cpu = cpu;
        sb_push("ext_long_hold_count", 1);
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (k == 39) ext_n = 1'b1;
            if (cpu && !prev_cpu) rises++;
            prev_cpu = cpu;
        end
        sb_check(rises);
        sb_push("ext_cause", 8'h08); sb_check(int'(bus.cause_out));
        sb_push("ext_back_to_run", 0); sb_check(int'(cpu));

        // Trap in the 10th HOLD cycle restarts the hold count
        clear_cause();
        @(negedge clk);
        wdt = 1'b1;
        sb_push("restart_first_both", 1);
        sb_push("restart_periph_fall", 27);
        sb_push("restart_cpu_fall", 31);
        measure(10, 3'b010, pf, cf, fb);
        sb_check(fb); sb_check(pf); sb_check(cf);
        sb_push("restart_cause", 8'h06); sb_check(int'(bus.cause_out));

        // Writes and sw_reset while cpu_reset=1 are ignored
        clear_cause();
        @(negedge clk);
        wdt = 1'b1;
        @(negedge clk);
        clear_drives();
        bus.hold_write  = 1'b1;
        bus.hold_in     = 8'h4D;
        bus.cause_write = 1'b1;
        bus.cause_in    = 8'hFF;
        bus.sw_reset    = 1'b1;
        sb_push("gated_periph_fall", 16);
        sb_push("gated_cpu_fall", 20);
        measure(0, 3'b000, pf, cf, fb);
        sb_check(pf); sb_check(cf);
        sb_push("gated_hold", 16);     sb_check(int'(bus.hold_out));
        sb_push("gated_cause", 8'h02); sb_check(int'(bus.cause_out));

        // cause clear of bit1 together with sw_reset
        @(negedge clk);
        bus.cause_write = 1'b1;
        bus.cause_in    = 8'h02;
        bus.sw_reset    = 1'b1;
        sb_push("swclr_periph_fall", 17);
        sb_push("swclr_cpu_fall", 21);
        sb_push("swclr_cause", 8'h10);
        measure(0, 3'b000, pf, cf, fb);
        sb_check(pf); sb_check(cf);
        sb_check(int'(bus.cause_out));

        // hold of 0 behaves as 1
        @(negedge clk);
        bus.hold_write = 1'b1;
        bus.hold_in    = 8'h00;
        @(negedge clk);
        clear_drives();
        bus.sw_reset = 1'b1;
        sb_push("hold0_periph_fall", 2);
        sb_push("hold0_cpu_fall", 6);
        measure(0, 3'b000, pf, cf, fb);
        sb_check(pf); sb_check(cf);

        // Power-on reset mid-STAGGER takes effect without a clock edge
        @(negedge clk);
        wdt = 1'b1;
        @(negedge clk);
        clear_drives();
        @(negedge clk);
        sb_push("stagger_periph", 0); sb_check(int'(periph));
        sb_push("stagger_cpu", 1);    sb_check(int'(cpu));
        #2;
        por_n = 1'b0;
        #1;
        sb_push("async_periph", 1);     sb_check(int'(periph));
        sb_push("async_cpu", 1);        sb_check(int'(cpu));
        sb_push("async_cause", 8'h01);  sb_check(int'(bus.cause_out));
        sb_push("async_hold", 16);      sb_check(int'(bus.hold_out));

        @(negedge clk);
        por_n = 1'b1;
        sb_push("repor_periph_fall", 64);
        sb_push("repor_cpu_fall", 68);
        measure(0, 3'b000, pf, cf, fb);
        sb_check(pf); sb_check(cf);

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter POR_CYCLES, default 64: reset hold length after power-on.
REQ-002 Parameter STAGGER_CYCLES, default 4: cycles between peripheral and CPU reset release.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16: consecutive synchronized-low cycles that qualify ext_reset_n.
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 power_on_reset_n  input  1  asynchronous, active-low reset.
REQ-006 wdt_reset  input  1  watchdog overflow reset request, synchronous to clk, active-high.
REQ-007 trap  input  1  CPU trap reset request, synchronous, active-high.
REQ-008 ext_reset_n  input  1  external reset button, asynchronous, active-low.
REQ-009 hold_in  input  8  write data for the hold register.
REQ-010 hold_write  input  1  write strobe for the hold register.
REQ-011 cause_in  input  8  write-1-to-clear mask for the cause register.
REQ-012 cause_write  input  1  write strobe for the cause register.
REQ-013 sw_reset  input  1  software reset request, single-cycle strobe.
REQ-014 periph_reset  output  1  active-high reset for peripherals, including the watchdog's power_on_reset.
REQ-015 cpu_reset  output  1  active-high reset for the CPU core.
REQ-016 hold_out  output  8  current hold register.
REQ-017 cause_out  output  8  cause register: bit0 POR, bit1 watchdog, bit2 trap, bit3 external, bit4 software, bits 7:5 read 0.

Function
REQ-018 The FSM SHALL have the states POR_HOLD, HOLD, STAGGER and RUN, with all outputs registered.
REQ-019 POR_HOLD SHALL assert both resets for POR_CYCLES cycles, then go to STAGGER.
REQ-020 In RUN, a qualified event (wdt_reset, trap, debounced external, sw_reset) SHALL move the FSM to HOLD, and both resets SHALL assert on the next clock edge (1-cycle latency).
REQ-021 HOLD SHALL assert both resets for max(hold_reg,1) cycles, so a hold_reg of 0 behaves as 1, then go to STAGGER.
REQ-022 STAGGER SHALL drive periph_reset=0 and cpu_reset=1 for STAGGER_CYCLES cycles, then go to RUN with both resets 0.
REQ-023 An event during HOLD or STAGGER SHALL return the FSM to HOLD with the hold counter restarted and both resets asserted.
REQ-024 An event during POR_HOLD SHALL set its cause bit without changing state or counter.
REQ-025 ext_reset_n SHALL pass through a 2-flop synchronizer, then a debounce counter, and SHALL generate exactly one event per low period once it has been low for DEBOUNCE_CYCLES consecutive cycles.
REQ-026 Any high sample of synchronized ext_reset_n SHALL clear the debounce counter.
REQ-027 Each event SHALL OR-set its cause bit in the same edge that the FSM reacts.
REQ-028 A cause_write SHALL clear the bits that are 1 in cause_in, and a set SHALL win over a clear in the same cycle.
REQ-029 hold_write SHALL update hold_reg, with the new value applying to the next HOLD entry only; a HOLD in progress SHALL keep its captured length.
REQ-030 hold_write, cause_write and sw_reset SHALL be ignored while cpu_reset=1.
REQ-031 Simultaneous events SHALL set all of their cause bits and cause a single HOLD entry.

Reset
REQ-032 On power_on_reset_n low, the block SHALL asynchronously enter POR_HOLD with periph_reset=1, cpu_reset=1, cause=8'h01, hold_reg=8'd16, and the counters, synchronizer and debounce logic cleared (synchronizer to 1).
REQ-033 Deassertion of power_on_reset_n SHALL begin the POR_CYCLES count on the first clk edge after release.

Structure
REQ-034 A shared package reset_pkg SHALL hold the FSM state enum, the cause bit index constants and the hold register reset value.
REQ-035 The synchronizer plus debouncer SHALL be one sub-module named reset_debounce, parameterized by DEBOUNCE_CYCLES.

Verification
REQ-036 Release power_on_reset_n, then count cycles: periph_reset falls after exactly 64 cycles and cpu_reset after 68; cause_out=8'h01.
REQ-037 In RUN, pulse wdt_reset for 1 cycle with hold_reg=16: both resets rise next cycle, periph_reset falls 16 cycles later and cpu_reset 4 after that; cause_out=8'h03.
REQ-038 Drive ext_reset_n low for 15 cycles, then high: no reset. Drive it low for 40 cycles: exactly one HOLD; cause bit3=1.
REQ-039 Pulse trap in the 10th cycle of a HOLD: the hold counter restarts, so reset lasts 10+16 cycles; cause bits 1 and 2 are both set.
REQ-040 Write cause_in=8'h02 in the same cycle as sw_reset: bit4 is set and bit1 is cleared; then write hold_in=0 and trigger: HOLD lasts 1 cycle.
REQ-041 Assert power_on_reset_n low mid-STAGGER: both resets are 1 immediately without waiting for clk, and cause returns to 8'h01.
